// File: rtl/uart_tx_fifo_pkg.sv
// Shared constants and FSM encodings for the UART transmit path.
package uart_tx_fifo_pkg;

  localparam int DBIT_DEF   = 8;
  localparam int ADDR_W_DEF = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } tx_state_t;

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Producer/transmitter-side signal bundle for the UART transmit FIFO.
interface uart_tx_fifo_if #(
  parameter int DBIT   = uart_tx_fifo_pkg::DBIT_DEF,
  parameter int ADDR_W = uart_tx_fifo_pkg::ADDR_W_DEF
);

  logic              i_wr;
  logic [DBIT-1:0]   i_wr_data;
  logic              i_tx_done_tick;
  logic              o_tx_start;
  logic [DBIT-1:0]   o_tx_data;
  logic              o_full;
  logic              o_empty;
  logic [ADDR_W:0]   o_count;
  logic              o_busy;
  logic              o_overflow;

  modport master (
    output i_wr, i_wr_data, i_tx_done_tick,
    input  o_tx_start, o_tx_data, o_full, o_empty, o_count, o_busy, o_overflow
  );

  modport slave (
    input  i_wr, i_wr_data, i_tx_done_tick,
    output o_tx_start, o_tx_data, o_full, o_empty, o_count, o_busy, o_overflow
  );

endinterface

// File: rtl/uart_fifo_mem.sv
// Circular byte store: register array, wrapping pointers and an occupancy count.
module uart_fifo_mem
  import uart_tx_fifo_pkg::*;
#(
  parameter int DBIT   = DBIT_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_wr,
  input  logic              i_rd,
  input  logic [DBIT-1:0]   i_wr_data,
  output logic [DBIT-1:0]   o_rd_data,
  output logic              o_full,
  output logic              o_empty,
  output logic [ADDR_W:0]   o_count
);

  localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(2**ADDR_W);
  localparam logic [ADDR_W:0] ONE   = (ADDR_W+1)'(1);

  logic [DBIT-1:0]   r_mem [2**ADDR_W];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_count;
  logic              r_full;
  logic              r_empty;
  logic              w_wr_ok;
  logic [ADDR_W:0]   w_count_next;

  // A pop in the same cycle frees a slot, so a write while full is still taken.
  assign w_wr_ok = i_wr && (!r_full || i_rd);

  always_comb begin
    w_count_next = r_count;
    case ({w_wr_ok, i_rd})
      2'b10:   w_count_next = r_count + ONE;
      2'b01:   w_count_next = r_count - ONE;
      default: w_count_next = r_count;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (w_wr_ok) r_mem[r_wr_ptr] <= i_wr_data;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_wr_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_rd)    r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= w_count_next;
      r_full  <= (w_count_next == DEPTH);
      r_empty <= (w_count_next == '0);
    end
  end

  assign o_rd_data = r_mem[r_rd_ptr];
  assign o_full    = r_full;
  assign o_empty   = r_empty;
  assign o_count   = r_count;

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffers producer bytes and launches them one at a time into the UART transmitter.
module uart_tx_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int DBIT   = DBIT_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic          i_clk,
  input  logic          i_reset,
  uart_tx_fifo_if.slave bus
);

  tx_state_t         r_state;
  tx_state_t         w_state_next;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic [ADDR_W:0]   w_count;
  logic [DBIT-1:0]   w_rd_data;
  logic              r_tx_start;
  logic [DBIT-1:0]   r_tx_data;
  logic              r_overflow;

  uart_fifo_mem #(
    .DBIT   (DBIT),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_wr      (bus.i_wr),
    .i_rd      (w_pop),
    .i_wr_data (bus.i_wr_data),
    .o_rd_data (w_rd_data),
    .o_full    (w_full),
    .o_empty   (w_empty),
    .o_count   (w_count)
  );

  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_pop        = 1'b1;
          w_state_next = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (bus.i_tx_done_tick) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // The transmitter latches data on start, so the slot is released at launch.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state    <= ST_IDLE;
      r_tx_start <= 1'b0;
      r_tx_data  <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_tx_start <= w_pop;
      if (w_pop) r_tx_data <= w_rd_data;
      r_overflow <= bus.i_wr && w_full && !w_pop;
    end
  end

  assign bus.o_tx_start = r_tx_start;
  assign bus.o_tx_data  = r_tx_data;
  assign bus.o_full     = w_full;
  assign bus.o_empty    = w_empty;
  assign bus.o_count    = w_count;
  assign bus.o_busy     = (r_state == ST_WAIT);
  assign bus.o_overflow = r_overflow;

endmodule
